alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 It SHALL have these ID-side inputs: id_valid 1, decoded instruction present; id_pc 32; id_rs1/id_rs2 5 each, source register indices; id_rs1_data/id_rs2_data 32 each, register-file read data; id_imm 32, sign-extended immediate; id_rd 5; id_we 1, register write; id_asel 1, 0=rs1 1=pc; id_bsel 1, 0=rs2 1=imm; id_alu_op 4, ALU operation code.
REQ-003 It SHALL have these control inputs: stall 1, downstream hold; flush 1, kill the EX slot.
REQ-004 It SHALL have these forwarding inputs: mem_we 1, mem_rd 5, mem_result 32 (EX/MEM producer); wb_we 1, wb_rd 5, wb_data 32 (MEM/WB producer).
REQ-005 It SHALL have these outputs: ex_valid 1; ALUA 32, ALUB 32 and ALUsrc 4, driven directly into the ALU; ex_rd 5; ex_we 1; ex_store_data 32, forwarded rs2 value; hazard_stall 1, request to hold ID/IF; bubble_cnt 32, count of inserted bubbles.

Function
REQ-006 On each rising edge with rst=0, stall=0, flush=0 and hazard_stall=0, the block SHALL capture all id_* fields into EX registers, with ex_valid<=id_valid.
REQ-007 With stall=1 and flush=0, every EX register SHALL hold its value.
REQ-008 flush=1 SHALL set ex_valid<=0 and ex_we<=0 on the next edge, taking priority over stall and hazard_stall; the other EX registers are don't-care.
REQ-009 Register indices and data SHALL be forwarded combinationally from the registered ex_rs1/ex_rs2 indices, with priority MEM > WB > register-file value.
REQ-010 A MEM match SHALL require mem_we=1, mem_rd==index and index!=0; a WB match uses wb_we/wb_rd under the same rule.
REQ-011 Index 0 SHALL never be forwarded; its operand SHALL be the captured register-file value.
REQ-012 Operand select: ALUA = ex_asel ? ex_pc : fwd_rs1; ALUB = ex_bsel ? ex_imm : fwd_rs2; ex_store_data = fwd_rs2 regardless of bsel.
REQ-013 ALUsrc SHALL equal the registered ex_alu_op, passed unmodified; the latency from ID capture to ALU inputs is exactly 1 cycle.
REQ-014 When ex_valid=0, ex_we SHALL be 0; ALUA, ALUB and ALUsrc remain driven but are don't-care.
REQ-015 bubble_cnt SHALL increment by 1, wrapping modulo 2^32, on every edge where the EX slot loads a bubble because of hazard_stall; flush-induced bubbles SHALL NOT count.

Reset
REQ-016 rst=1 on an edge SHALL clear every EX register and bubble_cnt to 0, giving ex_valid=0, ex_we=0, ALUA=0, ALUB=0, ALUsrc=4'b0000 (add), ex_rd=0 and ex_store_data=0.
REQ-017 rst SHALL override stall, flush and hazard; an instruction in flight at reset SHALL be discarded.

Configuration
REQ-018 Macro ALU_BYPASS_EN defined: the forwarding of REQ-009..011 SHALL be active, hazard_stall SHALL be tied 0, and bubble_cnt SHALL stay 0.
REQ-019 ALU_BYPASS_EN undefined: forwarding SHALL be removed, so operands come from the captured register-file data only.
REQ-020 In that case hazard_stall SHALL be asserted combinationally when id_valid=1 and a nonzero id_rs1 or id_rs2 (used per asel/bsel; rs2 is always used when id_we=0) equals ex_rd (with ex_valid & ex_we), mem_rd (with mem_we) or wb_rd (with wb_we).
REQ-021 While hazard_stall=1 and stall=0, the EX slot SHALL load a bubble (ex_valid<=0, ex_we<=0) and the upstream is responsible for holding ID.

Verification
REQ-022 Reset, then id: add, rs1=1 (data 5), rs2=2 (data 7), bsel=0 -> next cycle ALUA=5, ALUB=7, ALUsrc=0000, ex_valid=1.
REQ-023 BYPASS_EN, ex_rs1=3, mem_we=1, mem_rd=3, mem_result=0x11, wb_we=1, wb_rd=3, wb_data=0x22 -> ALUA=0x11; drop mem_we -> ALUA=0x22.
REQ-024 BYPASS_EN, ex_rs2=0, mem_we=1, mem_rd=0, mem_result=0xFFFF_FFFF -> ALUB equals captured rs2 data (0), not forwarded.
REQ-025 stall=1 for 3 cycles with new id_* values -> outputs unchanged; stall=1 and flush=1 together -> ex_valid=0 on the next edge.
REQ-026 No BYPASS_EN, ex holds rd=4 with we=1, and id reads rs1=4 -> hazard_stall=1, next ex_valid=0, bubble_cnt 0->1; after the producer retires, hazard_stall=0 and the instruction issues.
REQ-027 Assert rst mid-stall with ex_valid=1 -> next edge all outputs 0 and bubble_cnt=0.

Source files
------------

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_stage
//  Purpose  : ID/EX pipeline register and ALU operand selection. Captures the
//             decoded instruction, resolves operands and drives the ALU.
//             Build option ALU_BYPASS_EN: when defined, operands are forwarded
//             from the MEM and WB producers and no hazard stall is raised;
//             when undefined, operands come from captured register-file data
//             and RAW hazards are resolved by inserting bubbles.
//  Revision : 1.0  initial release
// ============================================================================
module alu_operand_stage (
    input  logic        clk,
    input  logic        rst,
    // Decoded instruction from ID
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rd,
    input  logic        id_we,
    input  logic        id_asel,
    input  logic        id_bsel,
    input  logic [3:0]  id_alu_op,
    // Pipeline control
    input  logic        stall,
    input  logic        flush,
    // Producers further down the pipe
    input  logic        mem_we,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    // EX-side outputs
    output logic        ex_valid,
    output logic [31:0] ALUA,
    output logic [31:0] ALUB,
    output logic [3:0]  ALUsrc,
    output logic [4:0]  ex_rd,
    output logic        ex_we,
    output logic [31:0] ex_store_data,
    output logic        hazard_stall,
    output logic [31:0] bubble_cnt
);

    localparam logic [4:0] c_REG_ZERO = 5'd0;

    logic        r_ex_valid;
    logic [31:0] r_ex_pc;
    logic [31:0] r_ex_rs1_data;
    logic [31:0] r_ex_rs2_data;
    logic [31:0] r_ex_imm;
    logic [4:0]  r_ex_rd;
    logic        r_ex_we;
    logic        r_ex_asel;
    logic        r_ex_bsel;
    logic [3:0]  r_ex_alu_op;
    logic [31:0] r_bubble_cnt;

    logic [31:0] w_fwd_rs1;
    logic [31:0] w_fwd_rs2;
    logic        w_hazard;

`ifdef ALU_BYPASS_EN
    logic [4:0]  r_ex_rs1;
    logic [4:0]  r_ex_rs2;

    // Source indices are only needed to steer the bypass muxes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rs1 <= c_REG_ZERO;
            r_ex_rs2 <= c_REG_ZERO;
        end else if (!flush && !stall && !w_hazard) begin
            r_ex_rs1 <= id_rs1;
            r_ex_rs2 <= id_rs2;
        end
    end

    // Forward the youngest producer (MEM before WB); x0 is never forwarded
    always_comb begin
        w_fwd_rs1 = r_ex_rs1_data;
        w_fwd_rs2 = r_ex_rs2_data;
        if (r_ex_rs1 != c_REG_ZERO && mem_we && mem_rd == r_ex_rs1)
            w_fwd_rs1 = mem_result;
        else if (r_ex_rs1 != c_REG_ZERO && wb_we && wb_rd == r_ex_rs1)
            w_fwd_rs1 = wb_data;
        if (r_ex_rs2 != c_REG_ZERO && mem_we && mem_rd == r_ex_rs2)
            w_fwd_rs2 = mem_result;
        else if (r_ex_rs2 != c_REG_ZERO && wb_we && wb_rd == r_ex_rs2)
            w_fwd_rs2 = wb_data;
    end

    assign w_hazard = 1'b0;
`else
    logic w_use_rs1;
    logic w_use_rs2;
    logic w_rs1_busy;
    logic w_rs2_busy;
    logic w_unused_fwd;

    // Without a bypass network the producer values are not consumed here
    assign w_unused_fwd = ^{mem_result, wb_data};

    // Operands come straight from the captured register-file read data
    always_comb begin
        w_fwd_rs1 = r_ex_rs1_data;
        w_fwd_rs2 = r_ex_rs2_data;
    end

    // RAW detection: a used, nonzero source pending in EX, MEM or WB stalls ID
    always_comb begin
        w_use_rs1  = !id_asel;
        w_use_rs2  = !id_bsel || !id_we;
        w_rs1_busy = (id_rs1 != c_REG_ZERO) &&
                     ((r_ex_valid && r_ex_we && r_ex_rd == id_rs1) ||
                      (mem_we && mem_rd == id_rs1) ||
                      (wb_we && wb_rd == id_rs1));
        w_rs2_busy = (id_rs2 != c_REG_ZERO) &&
                     ((r_ex_valid && r_ex_we && r_ex_rd == id_rs2) ||
                      (mem_we && mem_rd == id_rs2) ||
                      (wb_we && wb_rd == id_rs2));
        w_hazard   = id_valid && ((w_use_rs1 && w_rs1_busy) ||
                                  (w_use_rs2 && w_rs2_busy));
    end
`endif

    // EX slot update: reset > flush > stall > hazard bubble > capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= 32'd0;
            r_ex_rs1_data <= 32'd0;
            r_ex_rs2_data <= 32'd0;
            r_ex_imm      <= 32'd0;
            r_ex_rd       <= c_REG_ZERO;
            r_ex_we       <= 1'b0;
            r_ex_asel     <= 1'b0;
            r_ex_bsel     <= 1'b0;
            r_ex_alu_op   <= 4'b0000;
            r_bubble_cnt  <= 32'd0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
            r_ex_we    <= 1'b0;
        end else if (stall) begin
            r_ex_valid <= r_ex_valid;
        end else if (w_hazard) begin
            r_ex_valid   <= 1'b0;
            r_ex_we      <= 1'b0;
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end else begin
            r_ex_valid    <= id_valid;
            r_ex_pc       <= id_pc;
            r_ex_rs1_data <= id_rs1_data;
            r_ex_rs2_data <= id_rs2_data;
            r_ex_imm      <= id_imm;
            r_ex_rd       <= id_rd;
            r_ex_we       <= id_we && id_valid;
            r_ex_asel     <= id_asel;
            r_ex_bsel     <= id_bsel;
            r_ex_alu_op   <= id_alu_op;
        end
    end

    assign ex_valid      = r_ex_valid;
    assign ex_we         = r_ex_we;
    assign ex_rd         = r_ex_rd;
    assign ALUA          = r_ex_asel ? r_ex_pc  : w_fwd_rs1;
    assign ALUB          = r_ex_bsel ? r_ex_imm : w_fwd_rs2;
    assign ALUsrc        = r_ex_alu_op;
    assign ex_store_data = w_fwd_rs2;
    assign hazard_stall  = w_hazard;
    assign bubble_cnt    = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_stage
//  Purpose  : Scoreboard bench for alu_operand_stage. A driver issues directed
//             then random cycles and pushes the expected EX-side view into a
//             queue; a monitor pops one entry per cycle and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

`ifdef ALU_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic        rst, stall, flush, id_valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        we, asel, bsel;
        logic [3:0]  op;
        logic        mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_result;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } stim_t;

    // What the EX slot currently holds, as an instruction
    typedef struct {
        logic        valid, we, asel, bsel;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
    } slot_t;

    typedef struct {
        logic        valid, we, hz, full;
        logic [31:0] a, b, sd, bc;
        logic [4:0]  rd;
        logic [3:0]  op;
    } exp_t;

    logic        clk;
    logic        rst, id_valid, id_we, id_asel, id_bsel, stall, flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        mem_we, wb_we;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_data;
    logic        ex_valid, ex_we, hazard_stall;
    logic [31:0] ALUA, ALUB, ex_store_data, bubble_cnt;
    logic [3:0]  ALUsrc;
    logic [4:0]  ex_rd;

    alu_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rd(id_rd), .id_we(id_we), .id_asel(id_asel), .id_bsel(id_bsel),
        .id_alu_op(id_alu_op), .stall(stall), .flush(flush),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ALUA(ALUA), .ALUB(ALUB), .ALUsrc(ALUsrc),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_store_data(ex_store_data),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        expq[$];
    stim_t       cur;
    slot_t       slot;
    logic        prev_hz;
    logic [31:0] bubbles;
    bit          zero_state;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Value an instruction actually sees for a source register
    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf, input stim_t s);
        if (BYPASS && idx != 5'd0 && s.mem_we && s.mem_rd == idx) return s.mem_result;
        if (BYPASS && idx != 5'd0 && s.wb_we && s.wb_rd == idx) return s.wb_data;
        return rf;
    endfunction

    function automatic logic pending(input logic [4:0] idx, input stim_t s, input slot_t x);
        if (idx == 5'd0) return 1'b0;
        return (x.valid && x.we && x.rd == idx) || (s.mem_we && s.mem_rd == idx) ||
               (s.wb_we && s.wb_rd == idx);
    endfunction

    function automatic logic hazard(input stim_t s, input slot_t x);
        if (BYPASS || !s.id_valid) return 1'b0;
        return (!s.asel && pending(s.rs1, s, x)) ||
               ((!s.bsel || !s.we) && pending(s.rs2, s, x));
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; stall = s.stall; flush = s.flush; id_valid = s.id_valid;
        id_pc = s.pc; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rs1_data = s.d1;
        id_rs2_data = s.d2; id_imm = s.imm; id_rd = s.rd; id_we = s.we;
        id_asel = s.asel; id_bsel = s.bsel; id_alu_op = s.op;
        mem_we = s.mem_we; mem_rd = s.mem_rd; mem_result = s.mem_result;
        wb_we = s.wb_we; wb_rd = s.wb_rd; wb_data = s.wb_data;
    endtask

    // One clock: advance the model over the edge, then present new inputs
    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        if (cur.rst) begin
            slot = '{default: '0};
            bubbles = 32'd0;
            zero_state = 1'b1;
        end else if (cur.flush) begin
            slot.valid = 1'b0; slot.we = 1'b0; zero_state = 1'b0;
        end else if (cur.stall) begin
            zero_state = zero_state;
        end else if (prev_hz) begin
            slot.valid = 1'b0; slot.we = 1'b0; zero_state = 1'b0;
            bubbles = bubbles + 32'd1;
        end else begin
            slot.valid = cur.id_valid; slot.we = cur.id_valid && cur.we;
            slot.asel = cur.asel; slot.bsel = cur.bsel; slot.pc = cur.pc;
            slot.d1 = cur.d1; slot.d2 = cur.d2; slot.imm = cur.imm;
            slot.rs1 = cur.rs1; slot.rs2 = cur.rs2; slot.rd = cur.rd; slot.op = cur.op;
            zero_state = 1'b0;
        end
        #1;
        apply(s);
        cur = s;
        prev_hz = hazard(s, slot);
        e.valid = slot.valid;
        e.we    = slot.we;
        e.hz    = prev_hz;
        e.full  = slot.valid || zero_state;
        e.a     = slot.asel ? slot.pc : operand(slot.rs1, slot.d1, s);
        e.b     = slot.bsel ? slot.imm : operand(slot.rs2, slot.d2, s);
        e.sd    = operand(slot.rs2, slot.d2, s);
        e.bc    = bubbles;
        e.rd    = slot.rd;
        e.op    = slot.op;
        expq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: one expected entry per cycle, compared away from the clock edge
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
            chk("ex_we", {31'd0, ex_we}, {31'd0, e.we});
            chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, e.hz});
            chk("bubble_cnt", bubble_cnt, e.bc);
            if (e.full) begin
                chk("ALUA", ALUA, e.a);
                chk("ALUB", ALUB, e.b);
                chk("ALUsrc", {28'd0, ALUsrc}, {28'd0, e.op});
                chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
                chk("ex_store_data", ex_store_data, e.sd);
            end
        end
    end

    initial begin
        stim_t s;
        cur = idle();
        cur.rst = 1'b1;
        apply(cur);
        prev_hz = 1'b0;
        slot = '{default: '0};
        bubbles = 32'd0;
        zero_state = 1'b0;

        // Reset, then add x1(5) + x2(7)
        s = idle(); s.rst = 1'b1; step(s); step(s);
        s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd1; s.d1 = 32'd5; s.rs2 = 5'd2;
        s.d2 = 32'd7; s.rd = 5'd5; s.we = 1'b1; step(s);
        step(idle());

        // Stall three cycles with changing ID fields, then stall with flush
        s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd6; s.d1 = 32'hA; s.op = 4'd3; step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.stall = 1'b1; s.id_valid = 1'b1; s.pc = $urandom;
            s.d1 = $urandom; s.op = 4'(i + 7); s.rd = 5'(i + 9); step(s);
        end
        s = idle(); s.stall = 1'b1; s.flush = 1'b1; s.id_valid = 1'b1; step(s);
        step(idle());

        // Producer writes x4, consumer reads x4 and is held by upstream
        s = idle(); s.id_valid = 1'b1; s.rd = 5'd4; s.we = 1'b1; s.d1 = 32'h3; step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd4; s.d1 = 32'h44; s.rd = 5'd8; step(s);
        end
        step(idle());

        // Forward priority on rs1=3, then x0 must not forward on rs2
        s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd3; s.d1 = 32'h33; s.rs2 = 5'd0; step(s);
        s = idle(); s.mem_we = 1'b1; s.mem_rd = 5'd3; s.mem_result = 32'h11;
        s.wb_we = 1'b1; s.wb_rd = 5'd3; s.wb_data = 32'h22; step(s);
        s.mem_we = 1'b0; step(s);
        s = idle(); s.mem_we = 1'b1; s.mem_rd = 5'd0; s.mem_result = 32'hFFFF_FFFF; step(s);

        // Reset asserted while stalled with a valid instruction in EX
        s = idle(); s.id_valid = 1'b1; s.d1 = 32'h77; s.rd = 5'd2; s.we = 1'b1; s.op = 4'd5; step(s);
        s = idle(); s.stall = 1'b1; step(s);
        s.rst = 1'b1; step(s);
        step(idle());

        // Random traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            s.rst        = ($urandom_range(0, 99) == 0);
            s.stall      = ($urandom_range(0, 4) == 0);
            s.flush      = ($urandom_range(0, 9) == 0);
            s.id_valid   = ($urandom_range(0, 5) != 0);
            s.pc         = $urandom;
            s.d1         = $urandom;
            s.d2         = $urandom;
            s.imm        = $urandom;
            s.rs1        = 5'($urandom_range(0, 3));
            s.rs2        = 5'($urandom_range(0, 3));
            s.rd         = 5'($urandom_range(0, 3));
            s.we         = 1'($urandom_range(0, 1));
            s.asel       = ($urandom_range(0, 3) == 0);
            s.bsel       = 1'($urandom_range(0, 1));
            s.op         = 4'($urandom_range(0, 15));
            s.mem_we     = ($urandom_range(0, 2) == 0);
            s.mem_rd     = 5'($urandom_range(0, 3));
            s.mem_result = $urandom;
            s.wb_we      = ($urandom_range(0, 2) == 0);
            s.wb_rd      = 5'($urandom_range(0, 3));
            s.wb_data    = $urandom;
            step(s);
        end
        step(idle());
        step(idle());

        repeat (3) @(posedge clk);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
